ethernet_receiver: RTL and testbench
====================================

// Module: ethernet_receiver
// PURPOSE
// Receive-side counterpart of the Ethernet TX path. Accepts frames from the MAC RX AXI-stream
// and stores each frame in one of slot_p packet slots. Exposes the oldest complete frame to the
// PL side through a byte-addressed synchronous read port. Frames flagged bad (tuser), oversized,
// or arriving while every slot is full are dropped.
// PARAMETERS
// buf_size_p    2048  bytes per slot; power of 2; packet_size_width_lp=$clog2(buf_size_p)+1
// recv_width_p  64    AXI-stream data width in bits; 32 or 64 only
// slot_p        2     number of packet slots; power of 2, >=2
// PORTS
// clk_i                 in   1                  clock
// reset_i               in   1                  synchronous active-high reset
// rx_axis_tdata_i       in   recv_width_p       beat data; byte 0 = bits [7:0]
// rx_axis_tkeep_i       in   recv_width_p/8     contiguous low bytes valid
// rx_axis_tvalid_i      in   1                  beat valid
// rx_axis_tlast_i       in   1                  last beat of frame
// rx_axis_tuser_i       in   1                  frame error, sampled on the tlast beat
// rx_axis_tready_o      out  1                  = ~reset_i; the receiver never backpressures
// packet_avail_o        out  1                  read slot holds a committed frame
// packet_size_o         out  packet_size_width_lp  byte length of read-slot frame; 0 when !avail
// packet_ack_i          in   1                  PL finished with the frame; frees read slot
// buffer_read_v_i       in   1                  read request
// buffer_read_addr_i    in   $clog2(buf_size_p) byte address within the read slot
// buffer_read_op_size_i in   2                  0=1B 1=2B 2=4B 3=8B (3 illegal at width 32)
// buffer_read_data_o    out  recv_width_p       read data, zero-extended, 1-cycle latency
// receive_count_o       out  16                 frames committed, wraps
// drop_count_o          out  16                 frames dropped, wraps
// BEHAVIOUR
// Reset: all slots empty; wr/rd slot ptrs 0; state eIdle; word ptr 0; byte count 0; all outputs 0.
// Beat accepted iff tvalid & tready. FSM states: eIdle, eRecv, eDrop.
//  eIdle, beat: free = (full slots < slot_p), sampled before this cycle's ack.
//   - If free, the beat writes word 0 of the write slot; go to eRecv.
//   - Otherwise go to eDrop.
//   - A tlast on this beat finishes the frame this cycle (single-beat frame).
//  eRecv, beat: write at word ptr, ptr++, count += popcount(tkeep).
//   - Overflow: a beat arrives when ptr == buf_size_p/(recv_width_p/8). Discard the beat; go to eDrop.
//  eDrop: discard beats; tlast -> eIdle, drop_count_o++.
//  tlast in eRecv/eIdle path:
//   - tuser=1: drop; drop_count_o++.
//   - Otherwise commit: slot size = final count, slot full, wr ptr++ mod slot_p, receive_count_o++.
//   - Either way return to eIdle; ptr and count clear.
//  Each dropped frame counts exactly once; a drop never marks a slot full.
// Read side:
//  - packet_avail_o, packet_size_o reflect the rd-ptr slot and are registered state.
//  - A commit is visible the cycle after its tlast beat.
//  - Read: on read_v, data from the rd-ptr slot, byte addr A, size op -> bytes A..A+2^op-1,
//    right-aligned in buffer_read_data_o at the next edge.
//  - Without read_v, buffer_read_data_o holds.
//  - A must be aligned to 2^op; a misaligned read is a $error (sim), data undefined.
//  - Reading beyond packet_size_o returns stale slot contents.
//  - packet_ack_i with avail: rd slot empty, rd ptr++ mod slot_p. Ignored when !avail.
//  - Ack and commit in the same cycle both take effect. Full-count arithmetic: +1-1 = unchanged.
// Reset mid-frame returns to eIdle. The remaining beats of that frame are received as a new frame.
// Sim asserts: non-contiguous tkeep; partial tkeep on a non-last beat; recv_width_p not 32/64.
// TESTING
// 1 60B frame, w=64, 8 beats, last tkeep=8'h0F, tuser=0 -> next cycle avail=1, size=60, rx_cnt=1;
//   read addr 0 op3 -> beat0; addr 57 op0 -> byte 57 zero-ext.
// 2 slot_p=2, three 64B frames, no ack -> frames 1,2 committed, frame 3 dropped, drop_cnt=1;
//   ack -> size of frame 2; next frame accepted.
// 3 64B frame, tuser=1 on tlast -> avail stays 0, drop_cnt=1; next 64B frame lands at word 0, size=64.
// 4 2056B frame (257 beats) -> beat 257 dropped, tail discarded, drop_cnt=1; then 64B frame size=64.
// 5 Ack slot 1 in the same cycle frame 0's tlast commits -> rd ptr wraps 1->0, avail stays 1,
//   size updates to frame 0.
// 6 Assert reset on beat 4 of an 8-beat frame -> all outputs 0 next cycle;
//   the 4-beat tail commits as size 32.

Source files
------------

// File: rtl/ethernet_receiver.sv
// Ethernet RX frame buffer. Frames from the MAC AXI-stream are stored in a ring of packet slots.
// The oldest committed slot is exposed through a byte-addressed read port with one cycle of latency.
module ethernet_receiver #(
  parameter  int buf_size_p           = 2048,
  parameter  int recv_width_p         = 64,
  parameter  int slot_p               = 2,
  localparam int packet_size_width_lp = $clog2(buf_size_p) + 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [recv_width_p-1:0]         rx_axis_tdata_i,
  input  logic [recv_width_p/8-1:0]       rx_axis_tkeep_i,
  input  logic                            rx_axis_tvalid_i,
  input  logic                            rx_axis_tlast_i,
  input  logic                            rx_axis_tuser_i,
  output logic                            rx_axis_tready_o,
  output logic                            packet_avail_o,
  output logic [packet_size_width_lp-1:0] packet_size_o,
  input  logic                            packet_ack_i,
  input  logic                            buffer_read_v_i,
  input  logic [$clog2(buf_size_p)-1:0]   buffer_read_addr_i,
  input  logic [1:0]                      buffer_read_op_size_i,
  output logic [recv_width_p-1:0]         buffer_read_data_o,
  output logic [15:0]                     receive_count_o,
  output logic [15:0]                     drop_count_o
);

  localparam int bytes_lp   = recv_width_p / 8;
  localparam int words_lp   = buf_size_p / bytes_lp;
  localparam int waddr_w_lp = $clog2(words_lp);
  localparam int ptr_w_lp   = waddr_w_lp + 1;
  localparam int off_w_lp   = $clog2(bytes_lp);
  localparam int kcnt_w_lp  = off_w_lp + 1;
  localparam int slot_w_lp  = $clog2(slot_p);
  localparam int baddr_w_lp = $clog2(buf_size_p);
  localparam logic [ptr_w_lp-1:0] words_ptr_lp = ptr_w_lp'(words_lp);

  if (recv_width_p != 32 && recv_width_p != 64) begin : g_bad_width
    $error("ethernet_receiver: recv_width_p must be 32 or 64");
  end

  typedef enum logic [1:0] {eIdle, eRecv, eDrop} state_e;
  state_e state_r, state_n;

  logic [recv_width_p-1:0]         mem_r [slot_p*words_lp];
  logic [slot_p-1:0]               slot_full_r;
  logic [packet_size_width_lp-1:0] slot_size_r [slot_p];
  logic [slot_w_lp-1:0]            wr_slot_r, rd_slot_r;
  logic [ptr_w_lp-1:0]             word_ptr_r;
  logic [packet_size_width_lp-1:0] byte_count_r, byte_count_n;
  logic [kcnt_w_lp-1:0]            keep_cnt;
  logic [15:0]                     receive_count_r, drop_count_r;
  logic [recv_width_p-1:0]         read_data_r, read_word, read_shifted, read_mask;
  logic [bytes_lp-1:0]             keep_inc;
  logic [2:0]                      align_mask;
  logic beat, free, overflow, wr_en, commit, drop_inc;

  assign rx_axis_tready_o = ~reset_i;
  assign beat             = rx_axis_tvalid_i & rx_axis_tready_o;
  // Slots fill in ring order, so the write slot is free exactly when fewer than slot_p are full.
  assign free             = ~slot_full_r[wr_slot_r];
  assign overflow         = (word_ptr_r == words_ptr_lp);
  assign byte_count_n     = byte_count_r + packet_size_width_lp'(keep_cnt);

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < bytes_lp; i++) keep_cnt = keep_cnt + kcnt_w_lp'(rx_axis_tkeep_i[i]);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= eIdle;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      eIdle: if (beat && !rx_axis_tlast_i) state_n = free ? eRecv : eDrop;
      eRecv: if (beat) begin
        if (rx_axis_tlast_i) state_n = eIdle;
        else if (overflow)   state_n = eDrop;
      end
      eDrop: if (beat && rx_axis_tlast_i) state_n = eIdle;
      default: state_n = eIdle;
    endcase
  end

  always_comb begin
    wr_en    = 1'b0;
    commit   = 1'b0;
    drop_inc = 1'b0;
    case (state_r)
      eIdle: if (beat) begin
        wr_en = free;
        if (rx_axis_tlast_i) begin
          commit   = free & ~rx_axis_tuser_i;
          drop_inc = ~free | rx_axis_tuser_i;
        end
      end
      eRecv: if (beat) begin
        if (overflow) begin
          drop_inc = rx_axis_tlast_i;
        end else begin
          wr_en = 1'b1;
          if (rx_axis_tlast_i) begin
            commit   = ~rx_axis_tuser_i;
            drop_inc = rx_axis_tuser_i;
          end
        end
      end
      eDrop: drop_inc = beat & rx_axis_tlast_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_ptr_r   <= '0;
      byte_count_r <= '0;
    end else if (beat && rx_axis_tlast_i) begin
      word_ptr_r   <= '0;
      byte_count_r <= '0;
    end else if (wr_en) begin
      word_ptr_r   <= word_ptr_r + ptr_w_lp'(1);
      byte_count_r <= byte_count_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_r[{wr_slot_r, word_ptr_r[waddr_w_lp-1:0]}] <= rx_axis_tdata_i;
  end

  // Commit and ack touch different slots, so both may land in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_full_r     <= '0;
      wr_slot_r       <= '0;
      rd_slot_r       <= '0;
      receive_count_r <= '0;
      drop_count_r    <= '0;
      for (int i = 0; i < slot_p; i++) slot_size_r[i] <= '0;
    end else begin
      if (commit) begin
        slot_full_r[wr_slot_r] <= 1'b1;
        slot_size_r[wr_slot_r] <= byte_count_n;
        wr_slot_r              <= wr_slot_r + slot_w_lp'(1);
        receive_count_r        <= receive_count_r + 16'd1;
      end
      if (drop_inc) drop_count_r <= drop_count_r + 16'd1;
      if (packet_ack_i && slot_full_r[rd_slot_r]) begin
        slot_full_r[rd_slot_r] <= 1'b0;
        rd_slot_r              <= rd_slot_r + slot_w_lp'(1);
      end
    end
  end

  always_comb begin
    read_word    = mem_r[{rd_slot_r, buffer_read_addr_i[baddr_w_lp-1:off_w_lp]}];
    read_shifted = read_word >> {buffer_read_addr_i[off_w_lp-1:0], 3'b000};
    read_mask    = '0;
    for (int i = 0; i < bytes_lp; i++)
      if (i < (1 << buffer_read_op_size_i)) read_mask[i*8 +: 8] = 8'hFF;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)              read_data_r <= '0;
    else if (buffer_read_v_i) read_data_r <= read_shifted & read_mask;
  end

  assign packet_avail_o     = slot_full_r[rd_slot_r];
  assign packet_size_o      = slot_full_r[rd_slot_r] ? slot_size_r[rd_slot_r] : '0;
  assign buffer_read_data_o = read_data_r;
  assign receive_count_o    = receive_count_r;
  assign drop_count_o       = drop_count_r;

  assign keep_inc = rx_axis_tkeep_i + bytes_lp'(1);

  always_comb begin
    case (buffer_read_op_size_i)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  always @(posedge clk_i) begin
    if (!reset_i && beat) begin
      assert ((rx_axis_tkeep_i & keep_inc) == '0)
        else $error("ethernet_receiver: non-contiguous tkeep %h", rx_axis_tkeep_i);
      assert (rx_axis_tlast_i || (&rx_axis_tkeep_i))
        else $error("ethernet_receiver: partial tkeep %h on non-last beat", rx_axis_tkeep_i);
    end
    if (!reset_i && buffer_read_v_i) begin
      assert ((buffer_read_addr_i[2:0] & align_mask) == 3'b000)
        else $error("ethernet_receiver: misaligned read addr %0d op %0d", buffer_read_addr_i, buffer_read_op_size_i);
      assert (recv_width_p == 64 || buffer_read_op_size_i != 2'd3)
        else $error("ethernet_receiver: 8-byte read on 32-bit datapath");
    end
  end

endmodule

// File: tb/tb_ethernet_receiver.sv
// Directed bench for ethernet_receiver at default parameters (2048B slots, 64-bit stream, 2 slots).
module tb_ethernet_receiver;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] rx_axis_tdata_i;
  logic [7:0]  rx_axis_tkeep_i;
  logic        rx_axis_tvalid_i, rx_axis_tlast_i, rx_axis_tuser_i;
  logic        rx_axis_tready_o, packet_avail_o;
  logic [11:0] packet_size_o;
  logic        packet_ack_i, buffer_read_v_i;
  logic [10:0] buffer_read_addr_i;
  logic [1:0]  buffer_read_op_size_i;
  logic [63:0] buffer_read_data_o;
  logic [15:0] receive_count_o, drop_count_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  ethernet_receiver dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .rx_axis_tdata_i      (rx_axis_tdata_i),
    .rx_axis_tkeep_i      (rx_axis_tkeep_i),
    .rx_axis_tvalid_i     (rx_axis_tvalid_i),
    .rx_axis_tlast_i      (rx_axis_tlast_i),
    .rx_axis_tuser_i      (rx_axis_tuser_i),
    .rx_axis_tready_o     (rx_axis_tready_o),
    .packet_avail_o       (packet_avail_o),
    .packet_size_o        (packet_size_o),
    .packet_ack_i         (packet_ack_i),
    .buffer_read_v_i      (buffer_read_v_i),
    .buffer_read_addr_i   (buffer_read_addr_i),
    .buffer_read_op_size_i(buffer_read_op_size_i),
    .buffer_read_data_o   (buffer_read_data_o),
    .receive_count_o      (receive_count_o),
    .drop_count_o         (drop_count_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte i of a frame carries seed + i.
  function automatic logic [63:0] beat_data(input logic [7:0] seed, input int b);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = seed + 8'(b*8 + k);
    return d;
  endfunction

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic last,
                            input logic user, input logic ack);
    rx_axis_tdata_i  = d;
    rx_axis_tkeep_i  = k;
    rx_axis_tlast_i  = last;
    rx_axis_tuser_i  = user;
    rx_axis_tvalid_i = 1'b1;
    packet_ack_i     = ack;
    tick();
    rx_axis_tvalid_i = 1'b0;
    rx_axis_tlast_i  = 1'b0;
    rx_axis_tuser_i  = 1'b0;
    packet_ack_i     = 1'b0;
  endtask

  task automatic send_frame(input int nbytes, input logic [7:0] seed, input logic user,
                            input logic ack_on_last);
    int nbeats, rem;
    logic [7:0] k;
    logic last;
    nbeats = (nbytes + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      rem  = nbytes - b*8;
      k    = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      last = (b == nbeats - 1);
      drive_beat(beat_data(seed, b), k, last, last & user, last & ack_on_last);
    end
  endtask

  task automatic do_read(input logic [10:0] addr, input logic [1:0] op);
    buffer_read_v_i       = 1'b1;
    buffer_read_addr_i    = addr;
    buffer_read_op_size_i = op;
    tick();
    buffer_read_v_i = 1'b0;
  endtask

  task automatic do_ack();
    packet_ack_i = 1'b1;
    tick();
    packet_ack_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    rx_axis_tdata_i = '0; rx_axis_tkeep_i = '0; rx_axis_tvalid_i = 1'b0;
    rx_axis_tlast_i = 1'b0; rx_axis_tuser_i = 1'b0; packet_ack_i = 1'b0;
    buffer_read_v_i = 1'b0; buffer_read_addr_i = '0; buffer_read_op_size_i = '0;
    tick(); tick();
    check("rst_tready", 64'(rx_axis_tready_o), 64'd0);
    check("rst_avail", 64'(packet_avail_o), 64'd0);
    check("rst_size", 64'(packet_size_o), 64'd0);
    check("rst_rxcnt", 64'(receive_count_o), 64'd0);
    check("rst_dropcnt", 64'(drop_count_o), 64'd0);
    check("rst_data", buffer_read_data_o, 64'd0);
    reset_i = 1'b0;
    tick();
    check("tready_run", 64'(rx_axis_tready_o), 64'd1);

    // 60-byte frame, last beat keeps 4 bytes
    send_frame(60, 8'h00, 1'b0, 1'b0);
    check("t1_avail", 64'(packet_avail_o), 64'd1);
    check("t1_size", 64'(packet_size_o), 64'd60);
    check("t1_rxcnt", 64'(receive_count_o), 64'd1);
    do_read(11'd0, 2'd3);
    check("t1_rd_a0_op3", buffer_read_data_o, 64'h0706050403020100);
    do_read(11'd57, 2'd0);
    check("t1_rd_a57_op0", buffer_read_data_o, 64'h39);
    do_read(11'd58, 2'd1);
    check("t1_rd_a58_op1", buffer_read_data_o, 64'h3B3A);
    do_read(11'd4, 2'd2);
    check("t1_rd_a4_op2", buffer_read_data_o, 64'h07060504);
    tick();
    check("t1_rd_hold", buffer_read_data_o, 64'h07060504);
    do_ack();
    check("t1_ack_avail", 64'(packet_avail_o), 64'd0);
    check("t1_ack_size", 64'(packet_size_o), 64'd0);

    // Three frames with no ack: third finds both slots full
    send_frame(64, 8'h10, 1'b0, 1'b0);
    send_frame(40, 8'h20, 1'b0, 1'b0);
    send_frame(64, 8'h30, 1'b0, 1'b0);
    check("t2_rxcnt", 64'(receive_count_o), 64'd3);
    check("t2_dropcnt", 64'(drop_count_o), 64'd1);
    check("t2_size_a", 64'(packet_size_o), 64'd64);
    do_read(11'd0, 2'd3);
    check("t2_rd_a", buffer_read_data_o, 64'h1716151413121110);
    do_ack();
    check("t2_size_b", 64'(packet_size_o), 64'd40);
    do_read(11'd0, 2'd2);
    check("t2_rd_b", buffer_read_data_o, 64'h23222120);
    send_frame(24, 8'h40, 1'b0, 1'b0);
    check("t2_rxcnt_d", 64'(receive_count_o), 64'd4);
    check("t2_size_still_b", 64'(packet_size_o), 64'd40);
    do_ack();
    check("t2_size_d", 64'(packet_size_o), 64'd24);
    do_ack();
    check("t2_empty", 64'(packet_avail_o), 64'd0);
    do_ack();
    check("t2_ack_ignored", 64'(packet_avail_o), 64'd0);

    // Bad frame flagged by tuser, then a good one
    send_frame(64, 8'h50, 1'b1, 1'b0);
    check("t3_avail", 64'(packet_avail_o), 64'd0);
    check("t3_dropcnt", 64'(drop_count_o), 64'd2);
    check("t3_rxcnt", 64'(receive_count_o), 64'd4);
    send_frame(64, 8'h60, 1'b0, 1'b0);
    check("t3_avail2", 64'(packet_avail_o), 64'd1);
    check("t3_size2", 64'(packet_size_o), 64'd64);
    do_read(11'd0, 2'd3);
    check("t3_rd_word0", buffer_read_data_o, 64'h6766656463626160);
    do_ack();

    // Oversized frame: 257 full beats
    send_frame(2056, 8'h00, 1'b0, 1'b0);
    check("t4_dropcnt", 64'(drop_count_o), 64'd3);
    check("t4_avail", 64'(packet_avail_o), 64'd0);
    check("t4_rxcnt", 64'(receive_count_o), 64'd5);
    send_frame(64, 8'h70, 1'b0, 1'b0);
    check("t4_size", 64'(packet_size_o), 64'd64);
    check("t4_rxcnt2", 64'(receive_count_o), 64'd6);
    do_read(11'd56, 2'd3);
    check("t4_rd_a56", buffer_read_data_o, 64'hAFAEADACABAAA9A8);

    // Ack of slot 1 coincides with commit into slot 0
    send_frame(16, 8'h80, 1'b0, 1'b1);
    check("t5_avail", 64'(packet_avail_o), 64'd1);
    check("t5_size", 64'(packet_size_o), 64'd16);
    check("t5_rxcnt", 64'(receive_count_o), 64'd7);
    do_read(11'd8, 2'd3);
    check("t5_rd_a8", buffer_read_data_o, 64'h8F8E8D8C8B8A8988);
    do_ack();
    check("t5_empty", 64'(packet_avail_o), 64'd0);

    // Reset on beat 4 of an 8-beat frame; tail becomes its own frame
    for (int b = 0; b < 3; b++) drive_beat(beat_data(8'h90, b), 8'hFF, 1'b0, 1'b0, 1'b0);
    reset_i = 1'b1;
    drive_beat(beat_data(8'h90, 3), 8'hFF, 1'b0, 1'b0, 1'b0);
    check("t6_tready", 64'(rx_axis_tready_o), 64'd0);
    check("t6_avail", 64'(packet_avail_o), 64'd0);
    check("t6_size", 64'(packet_size_o), 64'd0);
    check("t6_rxcnt", 64'(receive_count_o), 64'd0);
    check("t6_dropcnt", 64'(drop_count_o), 64'd0);
    check("t6_data", buffer_read_data_o, 64'd0);
    reset_i = 1'b0;
    for (int b = 4; b < 8; b++) drive_beat(beat_data(8'h90, b), 8'hFF, b == 7, 1'b0, 1'b0);
    check("t6_tail_avail", 64'(packet_avail_o), 64'd1);
    check("t6_tail_size", 64'(packet_size_o), 64'd32);
    check("t6_tail_rxcnt", 64'(receive_count_o), 64'd1);
    check("t6_tail_dropcnt", 64'(drop_count_o), 64'd0);
    do_read(11'd0, 2'd3);
    check("t6_tail_rd", buffer_read_data_o, 64'hB7B6B5B4B3B2B1B0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
